// File: rtl/serial_add_pkg.sv
// Shared types and default sizing for the serial add/subtract controller.
package serial_add_pkg;

    localparam int W_DEF      = 5;
    localparam int NSLICE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle between operand source, controller and result consumer.
interface serial_add_ctrl_if #(parameter int DW = 20);

    logic          start_valid;
    logic          start_ready;
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic          cin;
    logic          sub;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] sum;
    logic          cout;
    logic          ovf;
    logic          busy;

    modport slave (
        input  start_valid, a_in, b_in, cin, sub, res_ready,
        output start_ready, res_valid, sum, cout, ovf, busy
    );

    modport master (
        output start_valid, a_in, b_in, cin, sub, res_ready,
        input  start_ready, res_valid, sum, cout, ovf, busy
    );

endinterface

// File: rtl/serial_add_ctrl_add_slice.sv
// Pure combinational W-bit adder slice shared across all slices of an operation.
module add_slice #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_s,
    output logic         o_cout
);

    logic [W:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
    assign o_s     = w_total[W-1:0];
    assign o_cout  = w_total[W];

endmodule

// File: rtl/serial_add_ctrl.sv
// W*NSLICE-bit add/subtract performed one W-bit slice per clock, LSB slice first,
// with the inter-slice carry held in a register.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int NSLICE = NSLICE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);

    localparam int DW = W * NSLICE;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [W-1:0]  r_sum_sl [NSLICE];
    logic          r_cout;
    logic          r_ovf;

    logic [W-1:0]  w_a_sl [NSLICE];
    logic [W-1:0]  w_b_sl [NSLICE];
    logic [DW-1:0] w_sum;
    logic [W-1:0]  w_s;
    logic          w_c;
    logic          w_accept;
    logic          w_start_ready;
    logic          w_res_valid;
    logic          w_busy;

    for (genvar g = 0; g < NSLICE; g++) begin : g_sl
        assign w_a_sl[g]         = r_a[g*W +: W];
        assign w_b_sl[g]         = r_b[g*W +: W];
        assign w_sum[g*W +: W]   = r_sum_sl[g];
    end

    add_slice #(.W(W)) u_slice (
        .i_a    (w_a_sl[r_idx]),
        .i_b    (w_b_sl[r_idx]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    assign w_accept = w_start_ready && bus.start_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start_valid) w_next = RUN;
                else                 w_next = IDLE;
            end
            RUN: begin
                if (r_idx == LAST_IDX) w_next = DONE;
                else                   w_next = RUN;
            end
            DONE: begin
                if (bus.res_ready) w_next = IDLE;
                else               w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        w_start_ready = 1'b0;
        w_res_valid   = 1'b0;
        w_busy        = 1'b0;
        case (r_state)
            IDLE:    w_start_ready = 1'b1;
            RUN:     w_busy        = 1'b1;
            DONE: begin
                w_res_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: w_start_ready = 1'b0;
        endcase
    end

    // Operand capture and slice-by-slice result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= {IW{1'b0}};
            r_carry <= 1'b0;
            r_a     <= {DW{1'b0}};
            r_b     <= {DW{1'b0}};
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < NSLICE; i++) r_sum_sl[i] <= {W{1'b0}};
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1; cin is deliberately ignored then.
            r_a     <= bus.a_in;
            r_b     <= bus.sub ? ~bus.b_in : bus.b_in;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_idx   <= {IW{1'b0}};
        end else if (r_state == RUN) begin
            r_sum_sl[r_idx] <= w_s;
            r_carry         <= w_c;
            if (r_idx == LAST_IDX) begin
                r_cout <= w_c;
                r_ovf  <= (r_a[DW-1] == r_b[DW-1]) && (w_s[W-1] != r_a[DW-1]);
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    assign bus.start_ready = w_start_ready;
    assign bus.res_valid   = w_res_valid;
    assign bus.busy        = w_busy;
    assign bus.sum         = w_sum;
    assign bus.cout        = r_cout;
    assign bus.ovf         = r_ovf;

endmodule
